icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, read-only instruction cache between the core fetch port (ADR_SI/ADR_VALID_SI,
//  IC_INST_SI/IC_STALL_SI) and the external instruction RAM bus.
//  Hits return the instruction in the same cycle. Misses stall ifetch and refill a whole line
//  with one-word request/ack transfers. A flush input invalidates all lines (fence.i).
// PARAMETERS
//  NB_LINES        64  number of lines; power of 2, >= 2
//  WORDS_PER_LINE  4   32-bit words per line; power of 2, >= 2
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  ADR_SI         in   32  fetch byte address from ifetch; bits [1:0] ignored
//  ADR_VALID_SI   in   1   fetch request valid
//  IC_FLUSH_SD    in   1   invalidate all lines (one-cycle pulse)
//  IC_INST_SI     out  32  instruction word for ADR_SI; valid when ADR_VALID_SI && !IC_STALL_SI
//  IC_STALL_SI    out  1   1 = instruction not available this cycle
//  RAM_ADR        out  32  word-aligned refill address (bits [1:0] = 0)
//  RAM_ADR_VALID  out  1   refill word request
//  RAM_DATA       in   32  refill data, sampled when RAM_ACK = 1
//  RAM_ACK        in   1   one-cycle pulse, one per word; may coincide with the first RAM_ADR_VALID cycle
// BEHAVIOUR
//  Address split: OFF = log2(WORDS_PER_LINE) word bits at [OFF+1:2]; IDX = log2(NB_LINES) bits
//    directly above OFF; TAG = remaining upper bits. Storage: valid[NB_LINES], tag[], data[][].
//  Reset: valid[] = 0; state = IDLE; word_cnt = 0; flush_pend = 0; RAM_ADR_VALID = 0; RAM_ADR = 0.
//    IC_INST_SI = 0 while reset = 1; IC_STALL_SI = ADR_VALID_SI while reset = 1.
//    Reset during REFILL abandons the line (it stays invalid). RAM_ACK is ignored in IDLE.
//  hit = valid[IDX] && tag[IDX] == TAG (combinational on ADR_SI).
//  FSM IDLE:
//    - IC_STALL_SI = ADR_VALID_SI && !hit; IC_INST_SI = data[IDX][OFF] on a hit, else 0.
//    - On a miss with no flush: latch line base (ADR_SI with offset bits and [1:0] cleared);
//      word_cnt <= 0; go to REFILL.
//    - IC_FLUSH_SD in IDLE: all valid <= 0 at the next edge; this cycle's hit still serves.
//  FSM REFILL:
//    - IC_STALL_SI = 1; RAM_ADR_VALID = 1; RAM_ADR = base + 4*word_cnt.
//    - On RAM_ACK: data[idx][word_cnt] <= RAM_DATA; word_cnt++.
//    - On the ack for word WORDS_PER_LINE-1: tag <= latched tag; valid <= !flush_pend;
//      flush_pend is applied (all valid <= 0), then cleared; go to IDLE.
//    - IC_FLUSH_SD during REFILL sets flush_pend.
//    - Changes of ADR_SI / ADR_VALID_SI during REFILL are ignored; the latched line completes.
//  Latency: hit = 0 cycles. Miss with ack every cycle = WORDS_PER_LINE+1 stall cycles
//    (1 IDLE miss cycle + WORDS_PER_LINE REFILL cycles); the hit occurs in the following IDLE cycle.
//  Same-index different-tag miss overwrites the line; no write path, no replacement state.
//  ADR_VALID_SI = 0 in IDLE: IC_STALL_SI = 0, no state change.
//  word_cnt wraps to 0 when the line completes; RAM_ADR never crosses a line boundary.
// TESTING
//  1 Cold miss: reset, ADR_SI=0x100, RAM acks every cycle with data=addr^0xA5A5A5A5
//    -> stall 5 cycles; RAM_ADR 0x100,0x104,0x108,0x10C; then IC_INST_SI=0xA5A5A4A5, stall=0.
//  2 Line hits: after test 1, fetch 0x104, 0x108, 0x10C back-to-back
//    -> no stall, no RAM_ADR_VALID, data = addr^0xA5A5A5A5.
//  3 Conflict: fetch 0x100 then 0x500 (same IDX, NB_LINES=64)
//    -> 0x500 misses and refills; a later 0x100 misses again.
//  4 Slow RAM: ack every 3rd cycle; ADR_SI changed to 0x200 mid-refill
//    -> the 0x100 line completes; then 0x200 misses; no ack is lost.
//  5 Flush: IC_FLUSH_SD pulse during REFILL of 0x300
//    -> after the refill ends 0x300 is still not valid; the next fetch of 0x100 or 0x300 misses.
//  6 Reset mid-refill after 2 acks -> stall and RAM_ADR_VALID low after reset;
//    the stray ack is ignored; the next fetch of 0x100 misses.

Source files
------------

// File: rtl/icache_direct_mapped_if.sv
// icache_direct_mapped_if: fetch-side and refill-side bus bundle for the instruction cache
interface icache_direct_mapped_if;
  logic [31:0] ADR_SI;
  logic        ADR_VALID_SI;
  logic        IC_FLUSH_SD;
  logic [31:0] IC_INST_SI;
  logic        IC_STALL_SI;
  logic [31:0] RAM_ADR;
  logic        RAM_ADR_VALID;
  logic [31:0] RAM_DATA;
  logic        RAM_ACK;
  modport slave (
    input  ADR_SI, ADR_VALID_SI, IC_FLUSH_SD, RAM_DATA, RAM_ACK,
    output IC_INST_SI, IC_STALL_SI, RAM_ADR, RAM_ADR_VALID
  );
  modport master (
    output ADR_SI, ADR_VALID_SI, IC_FLUSH_SD, RAM_DATA, RAM_ACK,
    input  IC_INST_SI, IC_STALL_SI, RAM_ADR, RAM_ADR_VALID
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with whole-line refill and flush
module icache_direct_mapped #(
  parameter int NB_LINES       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input logic                  clk,
  input logic                  reset,
  icache_direct_mapped_if.slave bus
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NB_LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;
  logic [0:0]          r_state;
  logic [NB_LINES-1:0] r_valid;
  logic [TW-1:0]       r_tag [NB_LINES];
  logic [31:0]         r_data [NB_LINES*WORDS_PER_LINE];
  logic [29-OW:0]      r_line;
  logic [OW-1:0]       r_word_cnt;
  logic                r_flush_pend;
  logic [OW-1:0]       w_off;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_ridx;
  logic [TW-1:0]       w_tag;
  logic                w_hit;
  logic                w_idle;
  logic                w_start;
  logic                w_ack;
  logic                w_last;
  logic                w_flush;
  assign w_off   = bus.ADR_SI[2 +: OW];
  assign w_idx   = bus.ADR_SI[2+OW +: IW];
  assign w_tag   = bus.ADR_SI[31 -: TW];
  assign w_ridx  = r_line[0 +: IW];
  assign w_hit   = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_idle  = r_state == S_IDLE;
  assign w_start = w_idle && !bus.IC_FLUSH_SD && bus.ADR_VALID_SI && !w_hit;
  assign w_ack   = !reset && !w_idle && bus.RAM_ACK;
  assign w_last  = w_ack && &r_word_cnt;
  assign w_flush = r_flush_pend || bus.IC_FLUSH_SD;
  assign bus.IC_STALL_SI   = reset ? bus.ADR_VALID_SI : (!w_idle || (bus.ADR_VALID_SI && !w_hit));
  assign bus.IC_INST_SI    = (!reset && w_idle && w_hit) ? r_data[{w_idx, w_off}] : '0;
  assign bus.RAM_ADR_VALID = !reset && !w_idle;
  assign bus.RAM_ADR       = w_idle ? '0 : {r_line, r_word_cnt, 2'b00};
  // control: miss detection, refill sequencing, valid bits and deferred flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_idle) begin
      if (bus.IC_FLUSH_SD) r_valid <= '0;
      else if (w_start) begin
        r_word_cnt <= '0;
        r_state    <= S_REFILL;
      end
    end else begin
      r_flush_pend <= !w_last && w_flush;
      if (w_ack) r_word_cnt <= r_word_cnt + OW'(1);
      if (w_last) begin
        r_state <= S_IDLE;
        if (w_flush) r_valid <= '0;
        else r_valid[w_ridx] <= 1'b1;
      end
    end
  end
  // datapath: latch the missing line address, store refill words, commit the tag on the last word
  always_ff @(posedge clk) begin
    if (w_start) r_line <= bus.ADR_SI[31:2+OW];
    if (w_ack) r_data[{w_ridx, r_word_cnt}] <= bus.RAM_DATA;
    if (w_last) r_tag[w_ridx] <= r_line[IW +: TW];
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: vector table, corner sequences and random fetches against a line-level model
module tb_icache_direct_mapped;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  icache_direct_mapped_if ifc();
  icache_direct_mapped #(.NB_LINES(64), .WORDS_PER_LINE(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
  typedef struct {logic [31:0] a; int period; bit hit;} vec_t;
  vec_t vt[11];
  int checks = 0;
  int errors = 0;
  int period = 1;
  int phase = 0;
  bit stray = 1'b0;
  logic s_stall, s_rv;
  logic [31:0] s_inst, s_ra;
  logic [31:0] acks[$];
  bit mv[64];
  int mt[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // one clock: sample outputs after settling, answer the RAM request, advance to the next falling edge
  task automatic cyc();
    #1;
    s_stall = ifc.IC_STALL_SI;
    s_inst  = ifc.IC_INST_SI;
    s_rv    = ifc.RAM_ADR_VALID;
    s_ra    = ifc.RAM_ADR;
    phase   = s_rv ? phase + 1 : 0;
    ifc.RAM_ACK  = stray || (s_rv && phase >= period);
    ifc.RAM_DATA = s_ra ^ K;
    if (s_rv && phase >= period) begin
      phase = 0;
      acks.push_back(s_ra);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.ADR_VALID_SI = 1'b0;
    ifc.IC_FLUSH_SD = 1'b0;
    cyc();
    reset = 1'b0;
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  // fetch until the stall drops; expected stall length follows from hit/miss and the RAM ack period
  task automatic fetch(input logic [31:0] a, input bit hit, input string nm);
    int n = 0;
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    ifc.ADR_SI = a;
    ifc.ADR_VALID_SI = 1'b1;
    acks.delete();
    do begin
      cyc();
      if (s_stall) n++;
    end while (s_stall && n < 200);
    chk({nm, " stalls"}, n, hit ? 0 : 1 + 4 * period);
    chk({nm, " inst"}, s_inst, {a[31:2], 2'b00} ^ K);
    chk({nm, " acks"}, acks.size(), hit ? 0 : 4);
    foreach (acks[i]) chk({nm, " ram_adr"}, acks[i], base + 32'(4 * i));
  endtask

  initial begin
    int n;
    vt[0]  = '{32'h100, 1, 1'b0};
    vt[1]  = '{32'h104, 1, 1'b1};
    vt[2]  = '{32'h108, 1, 1'b1};
    vt[3]  = '{32'h10C, 1, 1'b1};
    vt[4]  = '{32'h500, 1, 1'b0};
    vt[5]  = '{32'h504, 1, 1'b1};
    vt[6]  = '{32'h100, 1, 1'b0};
    vt[7]  = '{32'h50C, 1, 1'b0};
    vt[8]  = '{32'h200, 2, 1'b0};
    vt[9]  = '{32'h208, 2, 1'b1};
    vt[10] = '{32'h110, 1, 1'b0};
    ifc.ADR_SI = 32'h100;
    ifc.ADR_VALID_SI = 1'b1;
    ifc.IC_FLUSH_SD = 1'b0;
    ifc.RAM_DATA = '0;
    ifc.RAM_ACK = 1'b0;
    @(negedge clk);
    cyc();
    chk("reset stall", 32'(s_stall), 1);
    chk("reset inst", s_inst, 0);
    reset = 1'b0;
    ifc.ADR_VALID_SI = 1'b0;
    cyc();
    chk("post-reset stall", 32'(s_stall), 0);
    chk("post-reset ram_valid", 32'(s_rv), 0);
    chk("post-reset ram_adr", s_ra, 0);
    foreach (vt[i]) begin
      period = vt[i].period;
      fetch(vt[i].a, vt[i].hit, $sformatf("vec%0d", i));
    end
    ifc.ADR_VALID_SI = 1'b0;
    ifc.ADR_SI = 32'h999;
    cyc();
    chk("idle stall", 32'(s_stall), 0);
    chk("idle ram_valid", 32'(s_rv), 0);
    // slow RAM with the fetch address moving mid-refill
    do_reset();
    period = 3;
    ifc.ADR_SI = 32'h100;
    ifc.ADR_VALID_SI = 1'b1;
    acks.delete();
    repeat (4) cyc();
    ifc.ADR_SI = 32'h200;
    n = 0;
    while (acks.size() < 4 && n < 100) begin
      cyc();
      n++;
    end
    chk("slow acks", acks.size(), 4);
    foreach (acks[i]) chk("slow ram_adr", acks[i], 32'h100 + 32'(4 * i));
    fetch(32'h200, 1'b0, "slow next");
    fetch(32'h100, 1'b1, "slow kept");
    // flush during refill, then flush while idle
    do_reset();
    period = 1;
    fetch(32'h100, 1'b0, "flush fill");
    ifc.ADR_SI = 32'h300;
    acks.delete();
    cyc();
    cyc();
    ifc.IC_FLUSH_SD = 1'b1;
    cyc();
    ifc.IC_FLUSH_SD = 1'b0;
    n = 0;
    while (acks.size() < 4 && n < 50) begin
      cyc();
      n++;
    end
    chk("flush refill acks", acks.size(), 4);
    fetch(32'h300, 1'b0, "flush refilled");
    fetch(32'h100, 1'b0, "flush old");
    fetch(32'h104, 1'b1, "idle flush pre");
    ifc.IC_FLUSH_SD = 1'b1;
    cyc();
    ifc.IC_FLUSH_SD = 1'b0;
    chk("idle flush stall", 32'(s_stall), 0);
    chk("idle flush inst", s_inst, 32'h104 ^ K);
    fetch(32'h104, 1'b0, "idle flush post");
    // reset in the middle of a refill, then a stray ack while idle
    do_reset();
    fetch(32'h100, 1'b0, "rst fill");
    ifc.ADR_SI = 32'h500;
    acks.delete();
    n = 0;
    while (acks.size() < 2 && n < 50) begin
      cyc();
      n++;
    end
    reset = 1'b1;
    cyc();
    chk("mid reset stall", 32'(s_stall), 1);
    chk("mid reset inst", s_inst, 0);
    reset = 1'b0;
    ifc.ADR_VALID_SI = 1'b0;
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    chk("after reset stall", 32'(s_stall), 0);
    chk("after reset ram_valid", 32'(s_rv), 0);
    cyc();
    chk("stray ignored ram_valid", 32'(s_rv), 0);
    fetch(32'h100, 1'b0, "rst refetch");
    fetch(32'h500, 1'b0, "rst abandoned");
    // random fetches over a few conflicting tags, with occasional idle flushes
    do_reset();
    for (int k = 0; k < 150; k++) begin
      int t, x, o, lo;
      logic [31:0] a;
      bit h;
      period = int'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        ifc.ADR_VALID_SI = 1'b0;
        ifc.IC_FLUSH_SD = 1'b1;
        cyc();
        ifc.IC_FLUSH_SD = 1'b0;
        chk("rnd flush stall", 32'(s_stall), 0);
        foreach (mv[i]) mv[i] = 1'b0;
      end
      t  = int'($urandom_range(0, 3));
      x  = int'($urandom_range(0, 3));
      o  = int'($urandom_range(0, 3));
      lo = int'($urandom_range(0, 3));
      a  = 32'(t * 1024 + x * 16 + o * 4 + lo);
      h  = mv[x] && mt[x] == t;
      fetch(a, h, $sformatf("rnd%0d", k));
      mv[x] = 1'b1;
      mt[x] = t;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
